// File: rtl/b_resp_router_pkg.sv
// ---------------------------------------------------------------------------
// b_router_pkg
//   Shared definitions for the write-response router and its order queue:
//   AXI BRESP encodings and a constant-evaluable ceil(log2) helper used to
//   size index and occupancy fields from the block parameters.
// ---------------------------------------------------------------------------
package b_router_pkg;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  // Smallest r with (1 << r) >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/b_resp_router_if.sv
// ---------------------------------------------------------------------------
// b_resp_router_if
//   B-channel bundle between N_SLV slave ports and one master port.
//   Slave fields are flattened: slave k occupies [k*W +: W] of each vector.
//
//   modport master : used by the router (samples slave B channels and
//                    m_bready, drives s_bready and the master B channel)
//   modport slave  : used by the surrounding fabric / environment
// ---------------------------------------------------------------------------
interface b_resp_router_if #(
  parameter int N_SLV  = 5,
  parameter int SID_W  = 6,
  parameter int MID_W  = 2,
  parameter int USER_W = 6
);

  logic [N_SLV*SID_W-1:0]  s_bid;
  logic [N_SLV*2-1:0]      s_bresp;
  logic [N_SLV*USER_W-1:0] s_buser;
  logic [N_SLV-1:0]        s_bvalid;
  logic [N_SLV-1:0]        s_bready;

  logic [MID_W-1:0]        m_bid;
  logic [1:0]              m_bresp;
  logic [USER_W-1:0]       m_buser;
  logic                    m_bvalid;
  logic                    m_bready;

  modport master (
    input  s_bid, s_bresp, s_buser, s_bvalid, m_bready,
    output s_bready, m_bid, m_bresp, m_buser, m_bvalid
  );

  modport slave (
    output s_bid, s_bresp, s_buser, s_bvalid, m_bready,
    input  s_bready, m_bid, m_bresp, m_buser, m_bvalid
  );

endinterface

// File: rtl/b_resp_router_ord_fifo.sv
// ---------------------------------------------------------------------------
// b_ord_fifo
//   Small synchronous FIFO holding the slave index of each accepted write,
//   in issue order. The head entry is presented combinationally on o_data.
//
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_data (ignored when full, unless popping this cycle)
//   i_data     : entry to write
//   i_pop      : remove head entry (ignored when empty)
//   o_data     : head entry
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
//   o_count    : occupancy
// ---------------------------------------------------------------------------
module b_ord_fifo
  import b_router_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push at full is still taken when the head leaves in the same cycle:
  // the freed slot is the one being written, so occupancy stays at DEPTH.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: the storage array has no reset -- only pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/b_resp_router.sv
// ---------------------------------------------------------------------------
// b_resp_router
//   Returns AXI write responses from N_SLV slaves to one master in the order
//   the writes were issued. The address side pushes the target slave index
//   of every accepted AW; the head index picks which slave's B channel may
//   hand over its response. Indices >= N_SLV mark writes that hit no slave
//   and produce a local DECERR without touching any slave. The master B
//   channel is a single registered stage that sustains one response/cycle.
//
//   clk, reset : clock, asynchronous active-high reset
//   ord_push   : push ord_slv into the order queue
//   ord_slv    : slave index of the accepted AW
//   ord_full   : order queue full
//   ord_count  : order queue occupancy
//   ord_ovf    : sticky, a push arrived while full and could not be taken
//   b_hold     : when high, no response is taken from the slaves
//   bus        : slave B channels in, master B channel out (master modport)
// ---------------------------------------------------------------------------
module b_resp_router
  import b_router_pkg::*;
#(
  parameter  int N_SLV     = 5,
  parameter  int SID_W     = 6,
  parameter  int MID_W     = 2,
  parameter  int USER_W    = 6,
  parameter  int ORD_DEPTH = 4,
  localparam int SEL_W     = clog2(N_SLV + 1),
  localparam int CNT_W     = clog2(ORD_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ord_push,
  input  logic [SEL_W-1:0]   ord_slv,
  output logic               ord_full,
  output logic [CNT_W-1:0]   ord_count,
  output logic               ord_ovf,
  input  logic               b_hold,
  b_resp_router_if.master    bus
);

  logic [SEL_W-1:0]  w_head;
  logic              w_empty;
  logic              w_head_in_range;
  logic              w_out_free;
  logic              w_cap;
  logic              w_sel_bvalid;
  logic [SID_W-1:0]  w_sel_bid;
  logic [1:0]        w_sel_bresp;
  logic [USER_W-1:0] w_sel_buser;
  logic [N_SLV-1:0]  w_bready;
  logic              w_unused_bid;

  logic              r_bvalid;
  logic [MID_W-1:0]  r_bid;
  logic [1:0]        r_bresp;
  logic [USER_W-1:0] r_buser;
  logic              r_ovf;

  b_ord_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (ORD_DEPTH)
  ) u_ord_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (ord_push),
    .i_data  (ord_slv),
    .i_pop   (w_cap),
    .o_data  (w_head),
    .o_full  (ord_full),
    .o_empty (w_empty),
    .o_count (ord_count)
  );

  assign w_head_in_range = (w_head < SEL_W'(N_SLV));

  // Mux the head slave's B channel. Out-of-range heads select nothing.
  // NOTE: each combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel_bvalid = 1'b0;
    w_sel_bid    = '0;
    w_sel_bresp  = BRESP_OKAY;
    w_sel_buser  = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (w_head == SEL_W'(k)) begin
        w_sel_bvalid = bus.s_bvalid[k];
        w_sel_bid    = bus.s_bid[k*SID_W +: SID_W];
        w_sel_bresp  = bus.s_bresp[k*2 +: 2];
        w_sel_buser  = bus.s_buser[k*USER_W +: USER_W];
      end
    end
  end

  // The master side only carries the low MID_W bits of the slave BID.
  assign w_unused_bid = ^w_sel_bid;

  // Output stage can accept a new response if empty or being drained now.
  assign w_out_free = ~r_bvalid | bus.m_bready;

  // A decode-error head needs no slave response, so it captures as soon as
  // the output stage is free.
  assign w_cap = ~w_empty & ~b_hold & w_out_free &
                 (w_head_in_range ? w_sel_bvalid : 1'b1);

  always_comb begin
    w_bready = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (w_cap && (w_head == SEL_W'(k))) w_bready[k] = 1'b1;
    end
  end

  assign bus.s_bready = w_bready;

  // Output register: loads on capture, otherwise holds its payload; valid
  // drops only when the master takes it and nothing replaces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= BRESP_OKAY;
      r_buser  <= '0;
    end else if (w_cap) begin
      r_bvalid <= 1'b1;
      if (w_head_in_range) begin
        r_bid   <= w_sel_bid[MID_W-1:0];
        r_bresp <= w_sel_bresp;
        r_buser <= w_sel_buser;
      end else begin
        r_bid   <= '0;
        r_bresp <= BRESP_DECERR;
        r_buser <= '0;
      end
    end else if (bus.m_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Overflow only when the push is actually dropped (no pop frees a slot).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (ord_push && ord_full && !w_cap) begin
      r_ovf <= 1'b1;
    end
  end

  assign ord_ovf      = r_ovf;
  assign bus.m_bvalid = r_bvalid;
  assign bus.m_bid    = r_bid;
  assign bus.m_bresp  = r_bresp;
  assign bus.m_buser  = r_buser;

endmodule

// File: tb/tb_b_resp_router.sv
// ---------------------------------------------------------------------------
// tb_b_resp_router
//   Drives the router with directed scenarios and randomized traffic and
//   compares it each cycle with a transaction-level model: an order queue
//   of slave indices plus a one-deep output slot.
// ---------------------------------------------------------------------------
module tb_b_resp_router;
  import b_router_pkg::*;

  localparam int N      = 5;
  localparam int SID_W  = 6;
  localparam int MID_W  = 2;
  localparam int USER_W = 6;
  localparam int DEPTH  = 4;
  localparam int SEL_W  = clog2(N + 1);
  localparam int CNT_W  = clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             ord_push;
  logic [SEL_W-1:0] ord_slv;
  logic             ord_full;
  logic [CNT_W-1:0] ord_count;
  logic             ord_ovf;
  logic             b_hold;

  b_resp_router_if #(.N_SLV(N), .SID_W(SID_W), .MID_W(MID_W), .USER_W(USER_W)) bus ();

  b_resp_router #(
    .N_SLV(N), .SID_W(SID_W), .MID_W(MID_W), .USER_W(USER_W), .ORD_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ord_push  (ord_push),
    .ord_slv   (ord_slv),
    .ord_full  (ord_full),
    .ord_count (ord_count),
    .ord_ovf   (ord_ovf),
    .b_hold    (b_hold),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state
  bit                t_push;
  logic [SEL_W-1:0]  t_slv;
  bit                t_hold;
  bit                t_mready;
  logic              sv   [N];
  logic [SID_W-1:0]  sid  [N];
  logic [1:0]        srsp [N];
  logic [USER_W-1:0] susr [N];
  logic [N-1:0]      hs_mask;
  logic [N-1:0]      last_rdy;

  // Reference model
  int                q[$];
  bit                mv;
  logic [MID_W-1:0]  mb;
  logic [1:0]        mr;
  logic [USER_W-1:0] mu;
  bit                movf;

  int n_checks;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    ord_push      = t_push;
    ord_slv       = t_slv;
    b_hold        = t_hold;
    bus.m_bready  = t_mready;
    for (int k = 0; k < N; k++) begin
      bus.s_bvalid[k]                  = sv[k];
      bus.s_bid[k*SID_W +: SID_W]      = sid[k];
      bus.s_bresp[k*2 +: 2]            = srsp[k];
      bus.s_buser[k*USER_W +: USER_W]  = susr[k];
    end
  endtask

  task automatic clear_stim();
    t_push   = 1'b0;
    t_slv    = '0;
    t_hold   = 1'b0;
    t_mready = 1'b1;
    for (int k = 0; k < N; k++) begin
      sv[k]   = 1'b0;
      sid[k]  = '0;
      srsp[k] = '0;
      susr[k] = '0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    mv      = 1'b0;
    mb      = '0;
    mr      = '0;
    mu      = '0;
    movf    = 1'b0;
    hs_mask = '0;
  endtask

  task automatic check_outputs();
    check("m_bvalid",  32'(bus.m_bvalid), 32'(mv));
    check("m_bid",     32'(bus.m_bid),    32'(mb));
    check("m_bresp",   32'(bus.m_bresp),  32'(mr));
    check("m_buser",   32'(bus.m_buser),  32'(mu));
    check("ord_count", 32'(ord_count),    32'(q.size()));
    check("ord_full",  32'(ord_full),     32'(q.size() == DEPTH));
    check("ord_ovf",   32'(ord_ovf),      32'(movf));
  endtask

  // One clock: drive at negedge, check the combinational ready against the
  // model, advance the model, then check the registered outputs after the
  // rising edge.
  task automatic step();
    int           h;
    int           sz;
    bit           cap;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    drive();
    #1;
    sz  = q.size();
    h   = (sz > 0) ? q[0] : 0;
    cap = (sz > 0) && !t_hold && (!mv || t_mready) && ((h < N) ? (sv[h] == 1'b1) : 1'b1);
    exp_rdy = '0;
    if (cap && h < N) exp_rdy[h] = 1'b1;
    last_rdy = bus.s_bready;
    check("s_bready", 32'(bus.s_bready), 32'(exp_rdy));
    hs_mask = exp_rdy;
    if (cap) begin
      mv = 1'b1;
      if (h < N) begin
        mb = sid[h][MID_W-1:0];
        mr = srsp[h];
        mu = susr[h];
      end else begin
        mb = '0;
        mr = 2'b11;
        mu = '0;
      end
      void'(q.pop_front());
    end else if (t_mready) begin
      mv = 1'b0;
    end
    if (t_push) begin
      if (sz < DEPTH || cap) q.push_back(int'(t_slv));
      else movf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_bvalid", 32'(bus.m_bvalid), 32'd0);
    check("rst_async_count",  32'(ord_count),    32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    check("rst_s_bready", 32'(bus.s_bready), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    t_push   = 1'b0;
    ord_push = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    clear_stim();
    drive();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, literal expectations
    check("reset_bvalid",   32'(bus.m_bvalid), 32'd0);
    check("reset_bid",      32'(bus.m_bid),    32'd0);
    check("reset_bresp",    32'(bus.m_bresp),  32'd0);
    check("reset_buser",    32'(bus.m_buser),  32'd0);
    check("reset_count",    32'(ord_count),    32'd0);
    check("reset_full",     32'(ord_full),     32'd0);
    check("reset_ovf",      32'(ord_ovf),      32'd0);
    check("reset_s_bready", 32'(bus.s_bready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // In-order return: order 2 then 0, slave 0 answers first
    t_push = 1'b1; t_slv = 3'd2; step();
    t_slv = 3'd0; step();
    t_push = 1'b0;
    sv[0] = 1'b1; sid[0] = 6'h2D; srsp[0] = 2'b00; susr[0] = 6'h11;
    step();
    check("order_wait_rdy",    32'(last_rdy),     32'd0);
    check("order_wait_bvalid", 32'(bus.m_bvalid), 32'd0);
    sv[2] = 1'b1; sid[2] = 6'h1E; srsp[2] = 2'b10; susr[2] = 6'h15;
    step();
    check("order_s2_rdy",   32'(last_rdy),    32'd4);
    check("order_s2_bid",   32'(bus.m_bid),   32'd2);
    check("order_s2_bresp", 32'(bus.m_bresp), 32'd2);
    check("order_s2_buser", 32'(bus.m_buser), 32'h15);
    sv[2] = 1'b0;
    step();
    check("order_s0_rdy",   32'(last_rdy),    32'd1);
    check("order_s0_bid",   32'(bus.m_bid),   32'd1);
    check("order_s0_buser", 32'(bus.m_buser), 32'h11);
    sv[0] = 1'b0;

    // Master back-pressure for 3 cycles, then back-to-back drain
    t_mready = 1'b0;
    sv[1] = 1'b1; sid[1] = 6'h07; srsp[1] = 2'b01; susr[1] = 6'h2A;
    sv[3] = 1'b1; sid[3] = 6'h30; srsp[3] = 2'b10; susr[3] = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      t_push = (i < 2);
      t_slv  = (i == 0) ? 3'd1 : 3'd3;
      step();
      check("stall_rdy",    32'(last_rdy),     32'd0);
      check("stall_bid",    32'(bus.m_bid),    32'd1);
      check("stall_bvalid", 32'(bus.m_bvalid), 32'd1);
    end
    t_push = 1'b0; t_mready = 1'b1;
    step();
    check("drain1_rdy",   32'(last_rdy),    32'd2);
    check("drain1_bid",   32'(bus.m_bid),   32'd3);
    check("drain1_bresp", 32'(bus.m_bresp), 32'd1);
    sv[1] = 1'b0;
    step();
    check("drain2_rdy",    32'(last_rdy),     32'd8);
    check("drain2_bid",    32'(bus.m_bid),    32'd0);
    check("drain2_buser",  32'(bus.m_buser),  32'h3F);
    check("drain2_bvalid", 32'(bus.m_bvalid), 32'd1);
    sv[3] = 1'b0;
    step();
    check("drain_done_bvalid", 32'(bus.m_bvalid), 32'd0);

    // Fill, overflow, push+pop at full
    clear_stim(); do_reset();
    t_push = 1'b1; t_slv = 3'd0;
    repeat (4) step();
    check("fill_count", 32'(ord_count), 32'd4);
    check("fill_full",  32'(ord_full),  32'd1);
    check("fill_ovf",   32'(ord_ovf),   32'd0);
    step();
    check("ovf_count", 32'(ord_count), 32'd4);
    check("ovf_flag",  32'(ord_ovf),   32'd1);
    sv[0] = 1'b1; sid[0] = 6'h03; srsp[0] = 2'b00; susr[0] = 6'h01;
    t_slv = 3'd1;
    step();
    check("pushpop_full_count",  32'(ord_count),    32'd4);
    check("pushpop_full_bvalid", 32'(bus.m_bvalid), 32'd1);
    check("pushpop_full_ovf",    32'(ord_ovf),      32'd1);
    t_push = 1'b0; sv[0] = 1'b0;

    // Out-of-range index -> local DECERR
    clear_stim(); do_reset();
    t_push = 1'b1; t_slv = 3'd7; step();
    t_push = 1'b0; step();
    check("decerr_rdy",    32'(last_rdy),     32'd0);
    check("decerr_bresp",  32'(bus.m_bresp),  32'd3);
    check("decerr_bid",    32'(bus.m_bid),    32'd0);
    check("decerr_bvalid", 32'(bus.m_bvalid), 32'd1);
    check("decerr_count",  32'(ord_count),    32'd0);

    // b_hold blocks capture; reset mid-stream clears everything
    clear_stim(); do_reset();
    sv[0] = 1'b1; sid[0] = 6'h3E; srsp[0] = 2'b01; susr[0] = 6'h22;
    t_push = 1'b1; t_slv = 3'd0; step();
    t_push = 1'b0; t_hold = 1'b1;
    repeat (2) begin
      step();
      check("hold_rdy",    32'(last_rdy),     32'd0);
      check("hold_bvalid", 32'(bus.m_bvalid), 32'd0);
      check("hold_count",  32'(ord_count),    32'd1);
    end
    t_hold = 1'b0; t_mready = 1'b0; t_push = 1'b1; t_slv = 3'd4; sv[4] = 1'b1;
    step();
    check("hold_rel_bid",    32'(bus.m_bid),    32'd2);
    check("hold_rel_bvalid", 32'(bus.m_bvalid), 32'd1);
    check("hold_rel_count",  32'(ord_count),    32'd1);
    sv[0] = 1'b0;
    do_reset();

    // Randomized traffic
    clear_stim(); do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      t_push = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) t_slv = SEL_W'($urandom_range(N, 7));
      else                           t_slv = SEL_W'($urandom_range(0, N - 1));
      t_hold   = ($urandom_range(0, 7) == 0);
      t_mready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (hs_mask[k]) sv[k] = 1'b0;
        if (!sv[k] && $urandom_range(0, 2) == 0) begin
          sv[k]   = 1'b1;
          sid[k]  = SID_W'($urandom);
          srsp[k] = 2'($urandom);
          susr[k] = USER_W'($urandom);
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
